// File: rtl/face_scan_controller.sv
// face_scan_controller: scans a 3x3 sticker grid over one camera frame.
// Define FACE_SCAN_RETRY_EN to rescan faces that return invalid colour codes.
module face_scan_controller #(
  parameter int X0        = 200,
  parameter int Y0        = 120,
  parameter int PITCH     = 80,
  parameter int WIN_LOG2  = 3,
  parameter int COLOR_LAT = 1,
  parameter int MAX_RETRY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        frame_start,
  input  logic        pixel_valid,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic [7:0]  pix_r,
  input  logic [7:0]  pix_g,
  input  logic [7:0]  pix_b,
  output logic [7:0]  avg_red,
  output logic [7:0]  avg_green,
  output logic [7:0]  avg_blue,
  input  logic [2:0]  color_in,
  output logic [26:0] face_colors,
  output logic        face_valid,
  output logic        busy,
  output logic        scan_error
);

  localparam int SW  = 8 + 2 * WIN_LOG2;
  localparam int SH  = 2 * WIN_LOG2;
  localparam int WIN = 1 << WIN_LOG2;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FRAME,
    ACCUM,
    PRESENT,
    CAPTURE,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [3:0]  k_q, k_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  avg_r_q, avg_r_d;
  logic [7:0]  avg_g_q, avg_g_d;
  logic [7:0]  avg_b_q, avg_b_d;
  logic [26:0] face_q, face_d;
  logic        fv_q, fv_d;

  logic        acc_clr;
  logic        acc_en;
  logic [2:0]  col_hit;
  logic [2:0]  row_hit;

  logic [SW-1:0] sum_r_q [9];
  logic [SW-1:0] sum_g_q [9];
  logic [SW-1:0] sum_b_q [9];
  logic [SW-1:0] sum_r_d [9];
  logic [SW-1:0] sum_g_d [9];
  logic [SW-1:0] sum_b_d [9];

`ifdef FACE_SCAN_RETRY_EN
  logic [7:0] retry_q, retry_d;
  logic       inv_q, inv_d;
  logic       err_q, err_d;
  logic       bad_code;
  logic       scan_bad;

  assign bad_code = color_in[2] & color_in[1];
  assign scan_bad = inv_q | bad_code;
`endif

  // Window row/column decode of the current pixel coordinate
  always_comb begin
    col_hit = '0;
    row_hit = '0;
    for (int i = 0; i < 3; i++) begin
      col_hit[i] = (int'(hcount) >= X0 + i * PITCH) &&
                   (int'(hcount) <  X0 + i * PITCH + WIN);
      row_hit[i] = (int'(vcount) >= Y0 + i * PITCH) &&
                   (int'(vcount) <  Y0 + i * PITCH + WIN);
    end
  end

  // Per-cell channel sums: cleared when a scan (re)starts, summed in ACCUM
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        sum_r_d[r*3+c] = sum_r_q[r*3+c];
        sum_g_d[r*3+c] = sum_g_q[r*3+c];
        sum_b_d[r*3+c] = sum_b_q[r*3+c];
        if (acc_clr) begin
          sum_r_d[r*3+c] = '0;
          sum_g_d[r*3+c] = '0;
          sum_b_d[r*3+c] = '0;
        end else if (acc_en && row_hit[r] && col_hit[c]) begin
          sum_r_d[r*3+c] = sum_r_q[r*3+c] + SW'(pix_r);
          sum_g_d[r*3+c] = sum_g_q[r*3+c] + SW'(pix_g);
          sum_b_d[r*3+c] = sum_b_q[r*3+c] + SW'(pix_b);
        end
      end
    end
  end

  // Next-state and datapath control for the scan sequence
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    avg_r_d = avg_r_q;
    avg_g_d = avg_g_q;
    avg_b_d = avg_b_q;
    face_d  = face_q;
    fv_d    = 1'b0;
    acc_clr = 1'b0;
    acc_en  = 1'b0;
`ifdef FACE_SCAN_RETRY_EN
    retry_d = retry_q;
    inv_d   = inv_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WAIT_FRAME;
          k_d     = '0;
          acc_clr = 1'b1;
`ifdef FACE_SCAN_RETRY_EN
          retry_d = '0;
          inv_d   = 1'b0;
          err_d   = 1'b0;
`endif
        end
      end
      WAIT_FRAME: begin
        if (frame_start) begin
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (frame_start) begin
          state_d = PRESENT;
          k_d     = '0;
          cnt_d   = '0;
        end else begin
          acc_en = pixel_valid;
        end
      end
      PRESENT: begin
        if (cnt_q == 8'd0) begin
          avg_r_d = sum_r_q[k_q][SW-1:SH];
          avg_g_d = sum_g_q[k_q][SW-1:SH];
          avg_b_d = sum_b_q[k_q][SW-1:SH];
        end
        if (cnt_q == 8'(COLOR_LAT + 1)) begin
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      CAPTURE: begin
        face_d[int'(k_q)*3 +: 3] = color_in;
`ifdef FACE_SCAN_RETRY_EN
        inv_d = scan_bad;
`endif
        if (k_q != 4'd8) begin
          k_d     = k_q + 4'd1;
          cnt_d   = '0;
          state_d = PRESENT;
        end else begin
`ifdef FACE_SCAN_RETRY_EN
          if (scan_bad && int'(retry_q) < MAX_RETRY) begin
            retry_d = retry_q + 8'd1;
            inv_d   = 1'b0;
            acc_clr = 1'b1;
            k_d     = '0;
            state_d = WAIT_FRAME;
          end else begin
            err_d   = scan_bad;
            fv_d    = 1'b1;
            state_d = DONE;
          end
`else
          fv_d    = 1'b1;
          state_d = DONE;
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: sums, cell index, averages, face word
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      k_q     <= '0;
      cnt_q   <= '0;
      avg_r_q <= '0;
      avg_g_q <= '0;
      avg_b_q <= '0;
      face_q  <= '0;
      fv_q    <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        sum_r_q[i] <= '0;
        sum_g_q[i] <= '0;
        sum_b_q[i] <= '0;
      end
    end else begin
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      avg_r_q <= avg_r_d;
      avg_g_q <= avg_g_d;
      avg_b_q <= avg_b_d;
      face_q  <= face_d;
      fv_q    <= fv_d;
      for (int i = 0; i < 9; i++) begin
        sum_r_q[i] <= sum_r_d[i];
        sum_g_q[i] <= sum_g_d[i];
        sum_b_q[i] <= sum_b_d[i];
      end
    end
  end

`ifdef FACE_SCAN_RETRY_EN
  // Retry bookkeeping and sticky error flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      retry_q <= '0;
      inv_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      retry_q <= retry_d;
      inv_q   <= inv_d;
      err_q   <= err_d;
    end
  end

  assign scan_error = err_q;
`else
  logic unused_retry_cfg;

  assign unused_retry_cfg = ^MAX_RETRY;
  assign scan_error       = 1'b0;
`endif

  assign avg_red     = avg_r_q;
  assign avg_green   = avg_g_q;
  assign avg_blue    = avg_b_q;
  assign face_colors = face_q;
  assign face_valid  = fv_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_face_scan_controller.sv
// tb_face_scan_controller: vector table plus scoreboard queues for the
// face scan sequencer, with a registered classifier model.
module tb_face_scan_controller;

  localparam int X0    = 200;
  localparam int Y0    = 120;
  localparam int PITCH = 80;
  localparam int MAXR  = 2;
  localparam logic [23:0] DECOY = 24'h808080;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        frame_start;
  logic        pixel_valid;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [7:0]  pix_r;
  logic [7:0]  pix_g;
  logic [7:0]  pix_b;
  logic [7:0]  avg_red;
  logic [7:0]  avg_green;
  logic [7:0]  avg_blue;
  logic [2:0]  color_in;
  logic [26:0] face_colors;
  logic        face_valid;
  logic        busy;
  logic        scan_error;

  always #5 clock = ~clock;

  face_scan_controller dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .frame_start (frame_start),
    .pixel_valid (pixel_valid),
    .hcount      (hcount),
    .vcount      (vcount),
    .pix_r       (pix_r),
    .pix_g       (pix_g),
    .pix_b       (pix_b),
    .avg_red     (avg_red),
    .avg_green   (avg_green),
    .avg_blue    (avg_blue),
    .color_in    (color_in),
    .face_colors (face_colors),
    .face_valid  (face_valid),
    .busy        (busy),
    .scan_error  (scan_error)
  );

  typedef struct {
    int          mode;
    logic [26:0] face;
    logic        err;
    int          passes;
  } vec_t;

  logic [23:0] ctab [6];
  vec_t        vecs [4];
  logic [23:0] avg_q  [$];
  logic [26:0] face_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          fv_cnt   = 0;

  function automatic logic [2:0] classify(input logic [23:0] rgb);
    logic [2:0] code;
    code = 3'd0;
    for (int i = 1; i < 6; i++) begin
      if (rgb === ctab[i]) code = 3'(i);
    end
    if (rgb === 24'h010203) code = 3'd7;
    return code;
  endfunction

  // Registered classifier: one cycle from avg change to color_in
  always @(posedge clock or posedge reset) begin
    if (reset) color_in <= 3'd0;
    else color_in <= classify({avg_red, avg_green, avg_blue});
  end

  always @(negedge clock) begin
    if (face_valid === 1'b1) fv_cnt <= fv_cnt + 1;
  end

  function automatic logic [23:0] pix_of(int mode, int k, int x, int y);
    case (mode)
      1: return ctab[k % 6];
      2: begin
        if (k != 0) return 24'hFFFFFF;
        return ((x + y) % 2 == 1) ? 24'h0D0D0D : 24'h0A0A0A;
      end
      3: return (k == 4) ? 24'h010203 : 24'hFFFFFF;
      default: return 24'hFFFFFF;
    endcase
  endfunction

  function automatic logic [23:0] exp_avg(int mode, int k);
    if (mode == 2 && k == 0) return 24'h0B0B0B;
    return pix_of(mode, k, 0, 0);
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic put_pix(input int h, input int v, input logic [23:0] rgb,
                         input logic vld);
    hcount = 11'(h);
    vcount = 10'(v);
    {pix_r, pix_g, pix_b} = rgb;
    pixel_valid = vld;
    step();
  endtask

  task automatic send_frame(input int mode, input logic mid);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        int k, bx, by;
        k  = r * 3 + c;
        bx = X0 + c * PITCH;
        by = Y0 + r * PITCH;
        for (int y = 0; y < 8; y++) begin
          for (int x = 0; x < 8; x++) begin
            start = mid && (k == 4) && (x == 0) && (y == 0);
            put_pix(bx + x, by + y, pix_of(mode, k, x, y), 1'b1);
          end
        end
        start = 1'b0;
        put_pix(bx + 8, by, DECOY, 1'b1);
        put_pix(bx - 1, by + 7, DECOY, 1'b1);
        put_pix(bx, by + 8, DECOY, 1'b1);
        put_pix(bx + 7, by - 1, DECOY, 1'b1);
        put_pix(bx + 3, by + 3, DECOY, 1'b0);
      end
    end
    pixel_valid = 1'b0;
  endtask

  task automatic run_scan(input vec_t v, input logic coinc, input logic mid,
                          input string tag);
    int          fv0;
    logic [23:0] e;
    logic [26:0] ef;
    fv0 = fv_cnt;
    start = 1'b1;
    frame_start = coinc;
    step();
    start = 1'b0;
    frame_start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      put_pix(X0 + (i % 3) * PITCH, Y0 + (i / 3) * PITCH, DECOY, 1'b1);
    end
    pixel_valid = 1'b0;
    for (int p = 0; p < v.passes; p++) begin
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      for (int k = 0; k < 9; k++) avg_q.push_back(exp_avg(v.mode, k));
      if (p == v.passes - 1) face_q.push_back(v.face);
      send_frame(v.mode, mid && (p == 0));
      frame_start = 1'b1;
      put_pix(X0, Y0, DECOY, 1'b1);
      frame_start = 1'b0;
      pixel_valid = 1'b0;
      repeat (2) @(posedge clock);
      for (int k = 0; k < 9; k++) begin
        if (k > 0) repeat (4) @(posedge clock);
        @(negedge clock);
        e = avg_q.pop_front();
        check($sformatf("%s p%0d avg cell%0d", tag, p, k),
              {8'd0, avg_red, avg_green, avg_blue}, {8'd0, e});
      end
      @(posedge clock);
      @(negedge clock);
      check($sformatf("%s p%0d early face_valid", tag, p), face_valid, 0);
      @(posedge clock);
      @(negedge clock);
      if (p == v.passes - 1) begin
        ef = face_q.pop_front();
        check($sformatf("%s face_valid latency", tag), face_valid, 1);
        check($sformatf("%s face_colors", tag), face_colors, ef);
        check($sformatf("%s scan_error", tag), scan_error, v.err);
      end else begin
        check($sformatf("%s p%0d retry no face_valid", tag, p), face_valid, 0);
        check($sformatf("%s p%0d retry busy", tag, p), busy, 1);
      end
      @(posedge clock);
      @(negedge clock);
      check($sformatf("%s p%0d face_valid one cycle", tag, p), face_valid, 0);
      if (p == v.passes - 1) begin
        check($sformatf("%s idle busy", tag), busy, 0);
      end
      step();
    end
    check($sformatf("%s face_valid count", tag), fv_cnt - fv0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int fv0;
    ctab[0] = 24'hFFFFFF;
    ctab[1] = 24'hFF8000;
    ctab[2] = 24'h00C800;
    ctab[3] = 24'hC80000;
    ctab[4] = 24'h0000C8;
    ctab[5] = 24'hFFFF00;
    vecs[0] = '{0, 27'h0000000, 1'b0, 1};
    vecs[1] = '{1, 27'h222C688, 1'b0, 1};
    vecs[2] = '{2, 27'h0000000, 1'b0, 1};
`ifdef FACE_SCAN_RETRY_EN
    vecs[3] = '{3, 27'h0007000, 1'b1, MAXR + 1};
`else
    vecs[3] = '{3, 27'h0007000, 1'b0, 1};
`endif

    reset = 1'b1;
    start = 1'b0;
    frame_start = 1'b0;
    pixel_valid = 1'b0;
    hcount = '0;
    vcount = '0;
    {pix_r, pix_g, pix_b} = '0;
    repeat (3) step();
    reset = 1'b0;
    step();
    check("reset busy", busy, 0);
    check("reset face_valid", face_valid, 0);
    check("reset face_colors", face_colors, 0);
    check("reset avg", {avg_red, avg_green, avg_blue}, 0);
    check("reset scan_error", scan_error, 0);

    for (int i = 0; i < 4; i++) begin
      run_scan(vecs[i], 1'b0, 1'b0, $sformatf("vec%0d", i));
    end

    run_scan(vecs[1], 1'b1, 1'b1, "coinc_busy_start");

    start = 1'b1;
    step();
    start = 1'b0;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    for (int i = 0; i < 20; i++) put_pix(X0 + i % 8, Y0, 24'hFFFFFF, 1'b1);
    pixel_valid = 1'b0;
    check("accum busy", busy, 1);
    fv0 = fv_cnt;
    reset = 1'b1;
    #1;
    check("midscan reset busy", busy, 0);
    check("midscan reset face_colors", face_colors, 0);
    check("midscan reset avg", {avg_red, avg_green, avg_blue}, 0);
    check("midscan reset face_valid", face_valid, 0);
    step();
    reset = 1'b0;
    repeat (50) step();
    check("no face_valid after reset", fv_cnt - fv0, 0);
    check("idle after reset", busy, 0);

    run_scan(vecs[1], 1'b0, 1'b0, "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
